// File: rtl/pg_operand_stage_if.sv
// Handshake bundle for the P/G operand stage of the 65-bit prefix adder.
// Port cin is present only when PG_CIN_EN is defined.
interface pg_operand_stage_if #(
    parameter int unsigned WIDTH = 65
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef PG_CIN_EN
    logic             cin;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pi_out;
    logic [WIDTH-1:0] gi_out;

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
`ifdef PG_CIN_EN
        output cin,
`endif
        input  out_valid,
        output out_ready,
        input  pi_out,
        input  gi_out
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
`ifdef PG_CIN_EN
        input  cin,
`endif
        output out_valid,
        input  out_ready,
        output pi_out,
        output gi_out
    );
endinterface

// File: rtl/pg_operand_stage.sv
// Bitwise propagate/generate front end with a registered 2-entry skid buffer.
// Optional macro PG_CIN_EN folds a carry-in into bit 0.
module pg_operand_stage #(
    parameter int unsigned WIDTH = 65
) (
    input logic              clk,
    input logic              rst,
    pg_operand_stage_if.slave bus
);
    // Bit 0 = main valid, bit 1 = skid valid, so handshake outputs come straight from flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_pi_q, main_pi_d;
    logic [WIDTH-1:0] main_gi_q, main_gi_d;
    logic [WIDTH-1:0] skid_pi_q, skid_pi_d;
    logic [WIDTH-1:0] skid_gi_q, skid_gi_d;
    logic [WIDTH-1:0] new_pi, new_gi;
    logic             accept, drain;

    always_comb begin
        new_pi = bus.a ^ bus.b;
        new_gi = bus.a & bus.b;
`ifdef PG_CIN_EN
        new_pi[0] = bus.a[0] ^ bus.b[0] ^ bus.cin;
        new_gi[0] = (bus.a[0] & bus.b[0]) | ((bus.a[0] ^ bus.b[0]) & bus.cin);
`endif
    end

    assign bus.in_ready  = ~state_q[1];
    assign bus.out_valid = state_q[0];
    assign bus.pi_out    = main_pi_q;
    assign bus.gi_out    = main_gi_q;

    assign accept = bus.in_valid & ~state_q[1];
    assign drain  = state_q[0] & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        main_pi_d = main_pi_q;
        main_gi_d = main_gi_q;
        skid_pi_d = skid_pi_q;
        skid_gi_d = skid_gi_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    main_pi_d = new_pi;
                    main_gi_d = new_gi;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_pi_d = new_pi;
                    main_gi_d = new_gi;
                end else if (accept) begin
                    state_d   = FULL;
                    skid_pi_d = new_pi;
                    skid_gi_d = new_gi;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d   = ONE;
                    main_pi_d = skid_pi_q;
                    main_gi_d = skid_gi_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_pi_q <= '0;
            main_gi_q <= '0;
            skid_pi_q <= '0;
            skid_gi_q <= '0;
        end else begin
            state_q   <= state_d;
            main_pi_q <= main_pi_d;
            main_gi_q <= main_gi_d;
            skid_pi_q <= skid_pi_d;
            skid_gi_q <= skid_gi_d;
        end
    end
endmodule

// File: tb/tb_pg_operand_stage.sv
// Scoreboard bench for pg_operand_stage; expected P/G pushed on accept, popped on drain.
module tb_pg_operand_stage;
    localparam int unsigned W = 65;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2*W-1:0] sb[$];

    pg_operand_stage_if #(.WIDTH(W)) bus ();
    pg_operand_stage #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        logic [W-1:0] p, g;
        p    = a ^ b;
        g    = a & b;
        p[0] = a[0] ^ b[0] ^ c;
        g[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & c);
        return {p, g};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic set_cin(input logic c);
`ifdef PG_CIN_EN
        bus.cin = c;
`else
        if (c) $display("note: cin ignored in this build");
`endif
    endtask

    // One clock: sample at negedge, record transfers, return after posedge+1.
    task automatic tick(output logic drained, output logic [W-1:0] opi, output logic [W-1:0] ogi);
        logic c;
        @(negedge clk);
`ifdef PG_CIN_EN
        c = bus.cin;
`else
        c = 1'b0;
`endif
        drained = bus.out_valid & bus.out_ready;
        opi     = bus.pi_out;
        ogi     = bus.gi_out;
        if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.a, bus.b, c));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_initial();
        #3;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pi_out !== '0 || bus.gi_out !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: out_valid=%b in_ready=%b pi=%h gi=%h, required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.pi_out, bus.gi_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic d;
        logic [W-1:0] p, g;
        logic [2*W-1:0] e;
        bus.a = 65'h1_0000_0000_0000_00FF;
        bus.b = 65'h1_0000_0000_0000_0F0F;
        set_cin(1'b0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick(d, p, g);
        bus.in_valid = 1'b0;
        tick(d, p, g);
        n_checks++;
        if (d !== 1'b1 || p !== 65'h0_0000_0000_0000_0FF0 || g !== 65'h1_0000_0000_0000_000F) begin
            n_fail++;
            $display("FAIL single: valid=%b pi=%h gi=%h, required 1 %h %h", d, p, g,
                     65'h0_0000_0000_0000_0FF0, 65'h1_0000_0000_0000_000F);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if ({p, g} !== e) begin
            n_fail++;
            $display("FAIL single_sb: got %h, required %h", {p, g}, e);
        end
    endtask

    task automatic test_backpressure();
        logic d;
        logic [W-1:0] p, g;
        logic [2*W-1:0] e;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = rnd(); bus.b = rnd();
        tick(d, p, g);
        bus.a = rnd(); bus.b = rnd();
        tick(d, p, g);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0 || sb.size() != 2) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b queued=%0d, required 0 2", bus.in_ready, sb.size());
        end
        bus.out_ready = 1'b1;
        for (int unsigned k = 0; k < 2; k++) begin
            tick(d, p, g);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_checks++;
            if (d !== 1'b1 || {p, g} !== e) begin
                n_fail++;
                $display("FAIL bp_drain%0d: valid=%b got %h, required 1 %h", k, d, {p, g}, e);
            end
            if (k == 0) begin
                n_checks++;
                if (bus.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_ready: in_ready=%b, required 1", bus.in_ready);
                end
            end
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        logic d;
        logic [W-1:0] p, g;
        logic [2*W-1:0] e;
        int errs = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int unsigned i = 0; i <= 100; i++) begin
            if (i == 100) bus.in_valid = 1'b0;
            bus.a = rnd(); bus.b = rnd();
            set_cin(1'($urandom_range(0, 1)));
            tick(d, p, g);
            if (i > 0) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_checks++;
                if (d !== 1'b1 || {p, g} !== e) begin
                    n_fail++;
                    errs++;
                    if (errs < 5)
                        $display("FAIL stream%0d: valid=%b got %h, required 1 %h", i, d, {p, g}, e);
                end
            end
        end
        set_cin(1'b0);
        n_checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: queued=%0d out_valid=%b, required 0 0", sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_stall();
        logic d;
        logic [W-1:0] p, g;
        logic [2*W-1:0] e;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = rnd(); bus.b = rnd();
        tick(d, p, g);
        bus.in_valid = 1'b0;
        e = (sb.size() > 0) ? sb[0] : '0;
        for (int unsigned k = 0; k < 5; k++) begin
            bus.a = ~bus.a; bus.b = rnd();
            tick(d, p, g);
            n_checks++;
            if (bus.out_valid !== 1'b1 || {p, g} !== e) begin
                n_fail++;
                $display("FAIL stall%0d: valid=%b got %h, required 1 %h", k, bus.out_valid, {p, g}, e);
            end
        end
        bus.out_ready = 1'b1;
        tick(d, p, g);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (d !== 1'b1 || {p, g} !== e) begin
            n_fail++;
            $display("FAIL stall_drain: valid=%b got %h, required 1 %h", d, {p, g}, e);
        end
    endtask

    task automatic test_cin();
        logic d;
        logic [W-1:0] p, g;
        logic [2*W-1:0] e;
        logic [1:0] want[2];
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 65'd1; bus.b = 65'd0; set_cin(1'b1);
        tick(d, p, g);
        bus.a = 65'd0; bus.b = 65'd0; set_cin(1'b1);
`ifdef PG_CIN_EN
        want[0] = 2'b01;
        want[1] = 2'b10;
`else
        want[0] = 2'b10;
        want[1] = 2'b00;
`endif
        for (int unsigned k = 0; k < 2; k++) begin
            if (k == 1) bus.in_valid = 1'b0;
            tick(d, p, g);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_checks++;
            if (d !== 1'b1 || {p[0], g[0]} !== want[k] || {p, g} !== e) begin
                n_fail++;
                $display("FAIL cin%0d: valid=%b pi0/gi0=%b%b got %h, required 1 %b %h",
                         k, d, p[0], g[0], {p, g}, want[k], e);
            end
        end
        set_cin(1'b0);
    endtask

    task automatic test_reset_midstream();
        logic d;
        logic [W-1:0] p, g;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = rnd(); bus.b = rnd() | 65'd1;
        tick(d, p, g);
        bus.a = rnd() | 65'd1; bus.b = rnd();
        tick(d, p, g);
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_prefill: in_ready=%b out_valid=%b, required 0 1", bus.in_ready, bus.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pi_out !== '0 || bus.gi_out !== '0) begin
            n_fail++;
            $display("FAIL rst_async: out_valid=%b in_ready=%b pi=%h gi=%h, required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.pi_out, bus.gi_out);
        end
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        set_cin(1'b0);
        test_reset_initial();
        test_single();
        test_backpressure();
        test_stall();
        test_streaming();
        test_cin();
        test_reset_midstream();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
